// File: rtl/otter_intc_pkg.sv
// Shared types and constants for the OTTER interrupt controller.
package otter_intc_pkg;

    typedef enum logic [1:0] {
        INTC_IDLE,
        INTC_TAKE,
        INTC_ISR
    } intc_state_t;

    localparam int INTC_NUM_SRC_DEF = 4;

    // Widest supported source count; the top slices this down to NUM_SRC.
    localparam logic [7:0] INTC_MASK_RST = 8'hFF;

endpackage

// File: rtl/intc_sync_edge.sv
// Two-flop synchronizer, history flop and rising-edge detector for one
// asynchronous interrupt line.
module intc_sync_edge (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_rise
);

    logic       r_s1;
    logic       r_s2;
    logic       r_s3;
    logic [2:0] r_warm;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_s3   <= 1'b0;
            r_warm <= 3'b000;
        end else begin
            r_s1   <= i_d;
            r_s2   <= r_s1;
            r_s3   <= r_s2;
            r_warm <= {r_warm[1:0], 1'b1};
        end
    end

    // Until the history flop holds a real sample, a line already high at
    // reset release would look like a fresh edge; suppress it.
    assign o_rise = r_s2 & ~r_s3 & r_warm[2];

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller: pending/mask registers, fixed-priority select and
// the take/in-service sequencer feeding the CSR trap path.
module intr_ctrl
    import otter_intc_pkg::*;
#(
    parameter int NUM_SRC = INTC_NUM_SRC_DEF,
    parameter int CW      = $clog2(NUM_SRC)
) (
    input  logic               INTC_CLK,
    input  logic               INTC_RST_N,
    input  logic [NUM_SRC-1:0] INTC_IRQ,
    input  logic               INTC_MIE,
    input  logic               INTC_BOUNDARY,
    input  logic               INTC_MRET_EXEC,
    input  logic               INTC_MASK_WE,
    input  logic [NUM_SRC-1:0] INTC_MASK_WD,
    output logic               INTC_INT_TAKEN,
    output logic [CW-1:0]      INTC_CAUSE,
    output logic [NUM_SRC-1:0] INTC_PENDING,
    output logic [NUM_SRC-1:0] INTC_MASK,
    output logic               INTC_IN_ISR
);

    localparam logic [NUM_SRC-1:0] MASK_RST = INTC_MASK_RST[NUM_SRC-1:0];

    logic [NUM_SRC-1:0] w_rise;
    logic [NUM_SRC-1:0] w_eligible;
    logic [NUM_SRC-1:0] w_clr;
    logic [NUM_SRC-1:0] r_pending;
    logic [NUM_SRC-1:0] r_mask;
    logic [CW-1:0]      w_winner;
    logic [CW-1:0]      r_cause;
    logic               w_take;
    intc_state_t        r_state;
    intc_state_t        w_state_nxt;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        intc_sync_edge u_sync (
            .i_clk   (INTC_CLK),
            .i_rst_n (INTC_RST_N),
            .i_d     (INTC_IRQ[g]),
            .o_rise  (w_rise[g])
        );
    end

    assign w_eligible = r_pending & r_mask;

    // Scan high to low so the lowest set index is the one left standing.
    always_comb begin
        w_winner = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_winner = CW'(i);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        case (r_state)
            INTC_IDLE: begin
                if ((|w_eligible) && INTC_MIE && INTC_BOUNDARY) begin
                    w_take      = 1'b1;
                    w_state_nxt = INTC_TAKE;
                end
            end
            INTC_TAKE: w_state_nxt = INTC_ISR;
            INTC_ISR: begin
                if (INTC_MRET_EXEC) begin
                    w_state_nxt = INTC_IDLE;
                end
            end
            default: w_state_nxt = INTC_IDLE;
        endcase
    end

    always_comb begin
        w_clr = '0;
        if (w_take) begin
            w_clr[w_winner] = 1'b1;
        end
    end

    always_ff @(posedge INTC_CLK or negedge INTC_RST_N) begin
        if (!INTC_RST_N) begin
            r_state <= INTC_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A rise arriving on the winner as it is taken re-pends it (set wins).
    always_ff @(posedge INTC_CLK or negedge INTC_RST_N) begin
        if (!INTC_RST_N) begin
            r_pending <= '0;
            r_mask    <= MASK_RST;
            r_cause   <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_rise;
            if (INTC_MASK_WE) begin
                r_mask <= INTC_MASK_WD;
            end
            if (w_take) begin
                r_cause <= w_winner;
            end
        end
    end

    assign INTC_INT_TAKEN = (r_state == INTC_TAKE);
    assign INTC_IN_ISR    = (r_state == INTC_ISR);
    assign INTC_CAUSE     = r_cause;
    assign INTC_PENDING   = r_pending;
    assign INTC_MASK      = r_mask;

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl: reset, priority, gating, masking and
// asynchronous reset out of the in-service state.
module tb_intr_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] irq;
    logic       mie;
    logic       boundary;
    logic       mret;
    logic       mask_we;
    logic [3:0] mask_wd;
    logic       taken;
    logic [1:0] cause;
    logic [3:0] pending;
    logic [3:0] mask;
    logic       in_isr;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    intr_ctrl #(.NUM_SRC(4)) dut (
        .INTC_CLK       (clk),
        .INTC_RST_N     (rst_n),
        .INTC_IRQ       (irq),
        .INTC_MIE       (mie),
        .INTC_BOUNDARY  (boundary),
        .INTC_MRET_EXEC (mret),
        .INTC_MASK_WE   (mask_we),
        .INTC_MASK_WD   (mask_wd),
        .INTC_INT_TAKEN (taken),
        .INTC_CAUSE     (cause),
        .INTC_PENDING   (pending),
        .INTC_MASK      (mask),
        .INTC_IN_ISR    (in_isr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_taken"}, 32'(taken), 32'd0);
        check({tag, "_cause"}, 32'(cause), 32'd0);
        check({tag, "_pending"}, 32'(pending), 32'd0);
        check({tag, "_mask"}, 32'(mask), 32'hF);
        check({tag, "_in_isr"}, 32'(in_isr), 32'd0);
    endtask

    task automatic do_mret();
        mret = 1'b1;
        tick();
        mret = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        irq      = 4'b0000;
        mie      = 1'b0;
        boundary = 1'b0;
        mret     = 1'b0;
        mask_we  = 1'b0;
        mask_wd  = 4'b0000;
        tick();
        tick();
        rst_n = 1'b1;

        // Reset values hold for 10 cycles with idle inputs.
        for (int i = 0; i < 10; i++) begin
            tick();
            check_reset_outputs("rst_idle");
        end

        // Single source 2: pending after E2, strobe after E3.
        mie      = 1'b1;
        boundary = 1'b1;
        irq      = 4'b0100;
        tick();
        check("s2_pend_e0", 32'(pending), 32'h0);
        tick();
        check("s2_pend_e1", 32'(pending), 32'h0);
        tick();
        check("s2_pend_e2", 32'(pending), 32'h4);
        check("s2_taken_e2", 32'(taken), 32'd0);
        tick();
        check("s2_taken_e3", 32'(taken), 32'd1);
        check("s2_cause", 32'(cause), 32'd2);
        check("s2_pend_clr", 32'(pending), 32'h0);
        tick();
        check("s2_taken_once", 32'(taken), 32'd0);
        check("s2_in_isr", 32'(in_isr), 32'd1);
        irq = 4'b0000;
        tick();
        check("s2_isr_hold", 32'(in_isr), 32'd1);
        do_mret();
        check("s2_mret_idle", 32'(in_isr), 32'd0);

        // Sources 3 and 1 together: 1 first, 3 after mret.
        tick();
        irq = 4'b1010;
        tick();
        tick();
        tick();
        check("p_pend", 32'(pending), 32'hA);
        tick();
        check("p_taken1", 32'(taken), 32'd1);
        check("p_cause1", 32'(cause), 32'd1);
        check("p_pend_left", 32'(pending), 32'h8);
        tick();
        check("p_isr_no_nest", 32'(taken), 32'd0);
        tick();
        check("p_isr_hold", 32'(in_isr), 32'd1);
        check("p_cause1_hold", 32'(cause), 32'd1);
        do_mret();
        check("p_mret_taken", 32'(taken), 32'd0);
        check("p_mret_idle", 32'(in_isr), 32'd0);
        tick();
        check("p_taken3", 32'(taken), 32'd1);
        check("p_cause3", 32'(cause), 32'd3);
        check("p_pend_empty", 32'(pending), 32'h0);
        tick();
        do_mret();

        // Source 0 gated by MIE then by BOUNDARY.
        mie = 1'b0;
        irq = 4'b0001;
        tick();
        tick();
        tick();
        check("g_pend", 32'(pending), 32'h1);
        tick();
        tick();
        check("g_no_take_mie", 32'(taken), 32'd0);
        check("g_no_isr_mie", 32'(in_isr), 32'd0);
        mie      = 1'b1;
        boundary = 1'b0;
        tick();
        check("g_no_take_bnd", 32'(taken), 32'd0);
        boundary = 1'b1;
        tick();
        check("g_taken", 32'(taken), 32'd1);
        check("g_cause", 32'(cause), 32'd0);
        tick();
        do_mret();

        // Masked source latches pending but is not taken.
        irq     = 4'b0000;
        mask_we = 1'b1;
        mask_wd = 4'b1110;
        tick();
        mask_we = 1'b0;
        check("m_mask_wr", 32'(mask), 32'hE);
        tick();
        tick();
        irq = 4'b0001;
        tick();
        tick();
        tick();
        check("m_pend", 32'(pending), 32'h1);
        tick();
        check("m_no_take", 32'(taken), 32'd0);
        check("m_no_isr", 32'(in_isr), 32'd0);
        mask_we = 1'b1;
        mask_wd = 4'b1111;
        tick();
        mask_we = 1'b0;
        check("m_mask_f", 32'(mask), 32'hF);
        check("m_old_mask", 32'(taken), 32'd0);
        tick();
        check("m_taken", 32'(taken), 32'd1);
        check("m_cause", 32'(cause), 32'd0);
        tick();
        do_mret();

        // Async reset from ISR, then a held line must not re-request.
        irq = 4'b0000;
        tick();
        tick();
        tick();
        irq = 4'b0100;
        tick();
        tick();
        tick();
        tick();
        check("r_taken", 32'(taken), 32'd1);
        check("r_cause", 32'(cause), 32'd2);
        tick();
        mask_we = 1'b1;
        mask_wd = 4'b0011;
        tick();
        mask_we = 1'b0;
        check("r_isr_before", 32'(in_isr), 32'd1);
        check("r_mask_before", 32'(mask), 32'h3);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("r_async");
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("r_held_no_pend", 32'(pending), 32'h0);
            check("r_held_no_take", 32'(taken), 32'd0);
        end
        irq = 4'b0000;
        tick();
        tick();
        tick();
        tick();
        irq = 4'b0100;
        tick();
        tick();
        tick();
        check("r_fresh_pend", 32'(pending), 32'h4);
        tick();
        check("r_fresh_taken", 32'(taken), 32'd1);
        check("r_fresh_cause", 32'(cause), 32'd2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/intr_ctrl.md
# intr_ctrl

Interrupt controller that sequences the CSR's trap-entry/trap-return path for the OTTER MCU. Synchronizes and edge-detects several external interrupt sources, holds them as pending, picks one by fixed priority, and issues a single-cycle interrupt-taken strobe to the CSR and PC-select logic, only at an instruction boundary with mstatus.MIE set. It tracks in-service state until `mret` executes.

## Interface
Parameters:
- `NUM_SRC`, 4: number of interrupt sources, 2..8.
- `CW`, `$clog2(NUM_SRC)`: cause index width.

Ports:
- `INTC_CLK`  in  1  system clock, rising edge.
- `INTC_RST_N`  in  1  reset, asynchronous, active-low.
- `INTC_IRQ`  in  NUM_SRC  raw asynchronous interrupt lines, level-high; rising edge requests.
- `INTC_MIE`  in  1  mstatus bit 3 from CSR.
- `INTC_BOUNDARY`  in  1  MCU FSM is at an instruction boundary (fetch state) this cycle.
- `INTC_MRET_EXEC`  in  1  `mret` executing this cycle.
- `INTC_MASK_WE`  in  1  write enable for mask register.
- `INTC_MASK_WD`  in  NUM_SRC  mask write data; 1 = source enabled.
- `INTC_INT_TAKEN`  out  1  one-cycle strobe to CSR_INT_TAKEN / PC source.
- `INTC_CAUSE`  out  CW  index of source taken; valid from the TAKEN strobe until the next one.
- `INTC_PENDING`  out  NUM_SRC  pending bits, for debug/readback.
- `INTC_MASK`  out  NUM_SRC  current mask.
- `INTC_IN_ISR`  out  1  an interrupt is in service.

## Operation
- Per source: 2-flop synchronizer, then a history flop. `rise = s2 & ~s3`. A rise sets `pending[i]`. Held levels do not re-request.
- Mask: written when `INTC_MASK_WE`. Masked sources still latch pending. They are simply not eligible.
- `eligible = pending & mask`. Winner is the lowest set index (source 0 highest priority).
- FSM states, from the shared enum:
  - IDLE: if `eligible != 0 && INTC_MIE && INTC_BOUNDARY` -> TAKE. Latch cause = winner. Clear `pending[winner]`.
  - TAKE (exactly 1 cycle): `INTC_INT_TAKEN = 1`. Always -> ISR.
  - ISR: `INTC_IN_ISR = 1`. On `INTC_MRET_EXEC` -> IDLE. No new take while in ISR (no nesting).
- `INTC_INT_TAKEN` and `INTC_IN_ISR` decode from the state register (registered, glitch-free).
- `INTC_MRET_EXEC` in IDLE or TAKE: ignored.
- Same-cycle set and clear of one pending bit (new rise on the winner as it is taken): set wins, so the source re-pends.
- Mask write in the same cycle as a take decision: the decision uses the old mask.
- Async reset mid-operation (any state): immediately IDLE. All flops cleared, including synchronizers.

## Timing
- Reset values: `INTC_INT_TAKEN` 0, `INTC_CAUSE` 0, `INTC_PENDING` 0, `INTC_MASK` all-ones, `INTC_IN_ISR` 0, state IDLE.
- IRQ first sampled high at edge E0 -> s2 high after E1 -> `pending[i]` set at E2, visible after E2.
- Take decision at edge Ek, where conditions are true in the preceding cycle -> `INTC_INT_TAKEN` high for the cycle after Ek. `INTC_CAUSE` is updated at the same edge.
- Minimum IRQ-rise-to-strobe: strobe visible after E3, assuming boundary and MIE held.
- `mret` sampled at edge Em -> IDLE after Em. Earliest next strobe: after Em+1.
- Mask write takes effect after the write edge.

## Structure
- Package `otter_intc_pkg`:
  - `typedef enum logic [1:0] {INTC_IDLE, INTC_TAKE, INTC_ISR} intc_state_t`.
  - `INTC_NUM_SRC_DEF = 4`.
  - Mask reset constant.
- Sub-module `intc_sync_edge`: 2-flop synchronizer plus rise detector. One instance per source via generate. Async active-low reset.
- Top contains the pending register, mask register, priority encoder and FSM.

## Test plan
- Reset release, all inputs 0 -> every output at its reset value for 10 cycles. `INTC_MASK` = 4'hF.
- `INTC_IRQ` = 4'b0100 rises, MIE = 1, BOUNDARY = 1 held -> `INTC_PENDING[2]` set after E2, strobe after E3 for exactly 1 cycle. Then CAUSE = 2, PENDING = 0, IN_ISR = 1.
- IRQ 3 and IRQ 1 rise together -> CAUSE = 1 taken first and `PENDING` = 4'b1000. After `mret`, source 3 is taken at the next boundary.
- IRQ 0 pending with MIE = 0 or BOUNDARY = 0 -> no strobe. Raise both -> strobe on the next cycle.
- Mask = 4'b1110, IRQ 0 rises -> pending[0] = 1, no take. Write mask 4'hF -> take with CAUSE = 0.
- Assert `INTC_RST_N` low in the ISR state mid-cycle -> outputs return to reset values immediately, without waiting for a clock edge. IRQ held high after release -> no spurious take until a fresh rising edge.
